systolic_tile_ctrl: RTL and testbench
=====================================

Name: systolic_tile_ctrl

Overview:
- Sequences one output-stationary tile computation on an ARRAY_N x ARRAY_N grid of int8 MAC PEs.
- Clears the accumulators, then drives the operand-buffer read index for K reduction steps.
- Waits for the skewed wavefront to fully drain, then hands the results out one row per transfer over a valid/ready handshake.
- Sits between the host command interface and the array plus its edge operand feeders; the feeders apply the per-row/column skew and drive zeros whenever feed_valid is low.

Parameters:
ARRAY_N, 4, rows = columns of the PE grid (>=2)
K_WIDTH, 16, width of reduction length and feed index
ROW_W, $clog2(ARRAY_N), width of row_sel

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  launch a tile; sampled only in IDLE
k_len  in  K_WIDTH  reduction length K; captured when start is accepted
busy  out  1  high in every state except IDLE
accum_reset  out  1  drives the array accum_reset; high exactly in CLEAR
feed_valid  out  1  feeders present operands A[*][feed_k], B[feed_k][*]; low = feeders drive 0
feed_k  out  K_WIDTH  operand buffer read index
row_sel  out  ROW_W  result row presented to the array result mux
res_valid  out  1  row row_sel result is valid
res_ready  in  1  consumer accepts a row
res_last  out  1  high with res_valid when row_sel == ARRAY_N-1
done  out  1  one-cycle pulse at tile completion

Behaviour:
- Reset: state=IDLE, all outputs 0, captured K = 0, all counters 0. Reset applies in any state, including mid-tile; no done pulse is produced for an aborted tile.
- IDLE:
  - start=1 captures k_len and moves to CLEAR; busy is high from the next cycle.
  - start while busy is ignored, not queued.
- CLEAR (1 cycle): accum_reset=1, feed_valid=0.
  - Next state is FEED if K>0, else DRAIN.
- FEED (K cycles): feed_valid=1, feed_k counts 0..K-1, incrementing by 1 per cycle.
  - After the cycle with feed_k=K-1, go to DRAIN.
  - feed_k returns to 0 on exit.
- DRAIN (2*ARRAY_N-1 cycles): feed_valid=0.
  - Covers the 2*(ARRAY_N-1) skew and pipeline hops to PE(N-1,N-1), plus 1 cycle for the final accumulate.
  - The drain counter is sized $clog2(2*ARRAY_N)+1 bits; it clears on entry and on exit.
- READ:
  - res_valid=1; row_sel starts at 0.
  - On res_valid & res_ready, row_sel increments.
  - On the transfer with row_sel=ARRAY_N-1 (res_last=1), go to DONE.
  - row_sel, res_valid and res_last are stable while res_ready=0.
  - feed_valid stays 0 so accumulators hold.
- DONE (1 cycle): done=1, res_valid=0, then IDLE.
  - start is not accepted in DONE.
  - busy drops in the cycle after done.
- accum_reset and feed_valid are never high in the same cycle.
- Total latency, start-accept edge to first res_valid = 1 + K + (2*ARRAY_N-1) cycles.
- K=0: the tile is valid; the array outputs all-zero results.
- K width: the full K_WIDTH range is supported; the feed_k compare uses K-1 computed in K_WIDTH bits, guarded by the K>0 branch.
- All outputs are registered (Moore), except res_last, which is a decode of the registered row_sel and state.

Test Plan:
1. ARRAY_N=4, K=3, every A element = 1, every B element = 2 (bench array model):
   - accum_reset is high 1 cycle after start.
   - feed_k = 0,1,2.
   - DRAIN lasts 7 cycles.
   - res_valid rises 11 cycles after start accept.
   - All 16 results = 6; done is high 1 cycle after the 4th transfer.
2. K=0: CLEAR goes straight to DRAIN, feed_valid never high, 4 rows of zeros, done pulse.
3. Backpressure with res_ready toggling 1,0,0,1,...: every row is transferred exactly once, in order 0..3; row_sel and res_valid are stable while stalled; res_last only on row 3.
4. Back-to-back tiles, K=2 then K=5, start held high continuously:
   - The second tile launches only from IDLE, after the first done.
   - The second tile's results are unaffected by the first tile (accumulators cleared).
5. Reset asserted during FEED at feed_k=4 of K=8: the next cycle is IDLE with all outputs 0 and no done; a subsequent tile with K=1 completes correctly.
6. start pulsed during DRAIN and during READ: ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/systolic_tile_ctrl.sv
// systolic_tile_ctrl: sequences accumulator clear, K-step operand feed, wavefront drain and row readout for one output-stationary tile
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start_i, k_len_i  launch request (IDLE only) and reduction length captured on accept
//   busy_o            high in every state except IDLE
//   accum_reset_o     clears the PE accumulators (CLEAR only)
//   feed_valid_o      feeders present A[*][feed_k_o], B[feed_k_o][*]; low means feeders drive zeros
//   feed_k_o          operand buffer read index
//   row_sel_o         result row shown on the array result mux
//   res_valid_o, res_ready_i, res_last_o  row handshake; last flags row ARRAY_N-1
//   done_o            one-cycle completion pulse
module systolic_tile_ctrl #(
    parameter int ARRAY_N = 4,
    parameter int K_WIDTH = 16,
    parameter int ROW_W   = $clog2(ARRAY_N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [K_WIDTH-1:0] k_len_i,
    output logic               busy_o,
    output logic               accum_reset_o,
    output logic               feed_valid_o,
    output logic [K_WIDTH-1:0] feed_k_o,
    output logic [ROW_W-1:0]   row_sel_o,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic               res_last_o,
    output logic               done_o
);
    localparam int DW = $clog2(2 * ARRAY_N) + 1;
    // skew across both edges (2*(N-1)) plus the final accumulate
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(2 * ARRAY_N - 2);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ARRAY_N - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, READ, DONE} state_t;

    state_t             state_q, state_d;
    logic [K_WIDTH-1:0] k_q, k_d, feed_k_q, feed_k_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               busy_q, ar_q, fv_q, rv_q, done_q;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        feed_k_d = feed_k_q;
        drain_d  = drain_q;
        row_d    = row_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    k_d     = k_len_i;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                drain_d = '0;
                state_d = (k_q != '0) ? FEED : DRAIN;
            end
            FEED: begin
                // K-1 only evaluated here, where K>0 is guaranteed
                if (feed_k_q == k_q - K_WIDTH'(1)) begin
                    feed_k_d = '0;
                    state_d  = DRAIN;
                end else begin
                    feed_k_d = feed_k_q + K_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    state_d = READ;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            READ: begin
                if (res_ready_i) begin
                    row_d   = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                    state_d = (row_q == ROW_LAST) ? DONE : READ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // status flags registered from the next state so every output is a flop
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            feed_k_q <= '0;
            drain_q  <= '0;
            row_q    <= '0;
            busy_q   <= 1'b0;
            ar_q     <= 1'b0;
            fv_q     <= 1'b0;
            rv_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            feed_k_q <= feed_k_d;
            drain_q  <= drain_d;
            row_q    <= row_d;
            busy_q   <= state_d != IDLE;
            ar_q     <= state_d == CLEAR;
            fv_q     <= state_d == FEED;
            rv_q     <= state_d == READ;
            done_q   <= state_d == DONE;
        end
    end

    assign busy_o        = busy_q;
    assign accum_reset_o = ar_q;
    assign feed_valid_o  = fv_q;
    assign feed_k_o      = feed_k_q;
    assign row_sel_o     = row_q;
    assign res_valid_o   = rv_q;
    assign done_o        = done_q;
    assign res_last_o    = (state_q == READ) && (row_q == ROW_LAST);
endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// tb_systolic_tile_ctrl: table-driven tile runs with an array model and row scoreboard for systolic_tile_ctrl
module tb_systolic_tile_ctrl;
    localparam int N    = 4;
    localparam int KW   = 16;
    localparam int RW   = $clog2(N);
    localparam int A_EL = 1;
    localparam int B_EL = 2;

    typedef struct {
        int k;
        int rmode;
        int smode;
        int lat;
        int val;
    } vec_t;

    typedef struct {
        int row;
        int val;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, start, rr;
    logic [KW-1:0] k_len, fk;
    logic          busy, ar, fv, rv, rl, done;
    logic [RW-1:0] rs;

    int   acc [N][N];
    exp_t sb[$];
    vec_t tbl[7];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    systolic_tile_ctrl #(.ARRAY_N(N), .K_WIDTH(KW)) dut (
        .clk(clk), .rst(rst), .start_i(start), .k_len_i(k_len),
        .busy_o(busy), .accum_reset_o(ar), .feed_valid_o(fv), .feed_k_o(fk),
        .row_sel_o(rs), .res_valid_o(rv), .res_ready_i(rr), .res_last_o(rl),
        .done_o(done)
    );

    // unskewed array abstraction: every PE accumulates A*B per fed step
    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (rst || ar) acc[i][j] <= 0;
                else if (fv) acc[i][j] <= acc[i][j] + A_EL * B_EL;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] ctrl_now();
        return {busy, ar, fv, fk, rv, rs, rl, done};
    endfunction

    task automatic run_tile(input vec_t v);
        int i = 0;
        int row = 0;
        int rc = 0;
        bit fin = 0;
        bit bad;
        logic fv_e, rv_e;
        logic [KW-1:0] fk_e;
        logic [RW-1:0] rs_e;
        exp_t f;
        check("idle_before", busy, 0);
        start = 1'b1;
        k_len = KW'(v.k);
        for (int r = 0; r < N; r++) sb.push_back('{r, v.val});
        @(posedge clk);
        @(negedge clk);
        start = (v.smode == 1);
        k_len = KW'($urandom);
        while (!fin && i < v.lat + 200) begin
            fv_e = (i >= 1) && (i <= v.k);
            fk_e = fv_e ? KW'(i - 1) : '0;
            rv_e = (i >= v.lat) && (row < N);
            rs_e = rv_e ? RW'(row) : '0;
            check("ctrl", ctrl_now(),
                  {1'b1, i == 0, fv_e, fk_e, rv_e, rs_e, rv_e && row == N - 1, row == N});
            if (row == N) begin
                fin = 1;
            end else begin
                if (v.smode == 2) start = (i > v.k) && (i % 2 == 1);
                rr = (v.rmode == 0) ? 1'b1 : (v.rmode == 1) ? (rc % 3 == 0) : 1'($urandom % 2);
                if (rv_e) begin
                    rc++;
                    if (rr) begin
                        if (sb.size() == 0) begin
                            check("sb_underflow", 1, 0);
                        end else begin
                            f = sb.pop_front();
                            check("row_order", rs, f.row);
                            bad = 0;
                            for (int j = 0; j < N; j++) bad |= (acc[rs][j] != f.val);
                            check("row_data", acc[rs][0] + (bad ? 1000 : 0), f.val);
                        end
                        row++;
                    end
                end
                @(negedge clk);
                i++;
            end
        end
        if (!fin) check("timeout", 0, 1);
        if (v.smode != 1) start = 1'b0;
        rr = 1'b0;
        @(negedge clk);
        check("idle_after", ctrl_now(), 0);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rr = 1'b0; k_len = '0;
        tbl[0] = '{3, 0, 0, 11, 6};
        tbl[1] = '{0, 0, 0, 8, 0};
        tbl[2] = '{3, 1, 0, 11, 6};
        tbl[3] = '{2, 0, 1, 10, 4};
        tbl[4] = '{5, 0, 1, 13, 10};
        tbl[5] = '{4, 1, 2, 12, 8};
        tbl[6] = '{7, 2, 0, 15, 14};
        repeat (3) @(negedge clk);
        check("reset", ctrl_now(), 0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_idle", ctrl_now(), 0);
        for (int t = 0; t < 7; t++) run_tile(tbl[t]);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(8);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_feed_k", {fv, fk}, {1'b1, KW'(4)});
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid", ctrl_now(), 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_quiet", ctrl_now(), 0);
        end
        run_tile('{1, 0, 0, 9, 2});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
